// File: rtl/i2c_bus_arbiter.sv
// Two-requester arbiter for one shared I2C driver. Round-robin on ties, with a
// watchdog that revokes a grant held too long and locks out the offending requester.
module i2c_bus_arbiter #(
   parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
   input  logic       clk,
   input  logic       rst,
   // requester 0
   input  logic       req0,
   output logic       gnt0,
   input  logic       ena0,
   input  logic       rw0,
   input  logic       start_transfer0,
   input  logic       stop_transfer0,
   input  logic       r_start0,
   input  logic [7:0] data_wr0,
   output logic [7:0] data_rd0,
   output logic       busy0,
   output logic       ready0,
   output logic       ack_err0,
   // requester 1
   input  logic       req1,
   output logic       gnt1,
   input  logic       ena1,
   input  logic       rw1,
   input  logic       start_transfer1,
   input  logic       stop_transfer1,
   input  logic       r_start1,
   input  logic [7:0] data_wr1,
   output logic [7:0] data_rd1,
   output logic       busy1,
   output logic       ready1,
   output logic       ack_err1,
   // shared driver
   output logic       drv_ena,
   output logic       drv_rw,
   output logic       drv_start_transfer,
   output logic       drv_stop_transfer,
   output logic       drv_r_start,
   output logic [7:0] drv_data_wr,
   input  logic [7:0] drv_data_rd,
   input  logic       drv_busy,
   input  logic       drv_ready,
   input  logic       drv_ack_err,
   output logic       timeout_err
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_GRANT0  = 3'd1,
      S_GRANT1  = 3'd2,
      S_RELEASE = 3'd3,
      S_ABORT   = 3'd4
   } state_t;

   localparam logic [19:0] WDOG_LAST = 20'(TIMEOUT_CYCLES - 1);

   state_t      r_state;
   state_t      w_state_nxt;
   logic        r_last;
   logic [19:0] r_wdog;
   logic        r_lock0;
   logic        r_lock1;
   logic        r_terr;

   logic        w_elig0;
   logic        w_elig1;
   logic        w_req_own;
   logic        w_exit;
   logic        w_timeout;
   logic        w_in_grant;

   always_comb begin
      w_elig0    = req0 && !r_lock0;
      w_elig1    = req1 && !r_lock1;
      w_in_grant = (r_state == S_GRANT0) || (r_state == S_GRANT1);
      w_req_own  = (r_state == S_GRANT1) ? req1 : req0;
      w_exit     = !w_req_own && !drv_busy;
      w_timeout  = (r_wdog == WDOG_LAST);
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_elig0 && w_elig1)
               w_state_nxt = r_last ? S_GRANT0 : S_GRANT1;
            else if (w_elig0)
               w_state_nxt = S_GRANT0;
            else if (w_elig1)
               w_state_nxt = S_GRANT1;
         end
         S_GRANT0, S_GRANT1: begin
            // a clean release beats the watchdog when both land on the same cycle
            if (w_exit)
               w_state_nxt = S_RELEASE;
            else if (w_timeout)
               w_state_nxt = S_ABORT;
         end
         S_RELEASE: w_state_nxt = S_IDLE;
         S_ABORT: begin
            if (!drv_busy)
               w_state_nxt = S_RELEASE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_last  <= 1'b1;
         r_wdog  <= '0;
         r_lock0 <= 1'b0;
         r_lock1 <= 1'b0;
         r_terr  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_terr  <= (w_state_nxt == S_ABORT) && (r_state != S_ABORT);

         if (r_state == S_IDLE && w_state_nxt == S_GRANT0) begin
            r_last <= 1'b0;
            r_wdog <= '0;
         end else if (r_state == S_IDLE && w_state_nxt == S_GRANT1) begin
            r_last <= 1'b1;
            r_wdog <= '0;
         end else if (w_in_grant) begin
            r_wdog <= r_wdog + 20'd1;
         end

         // lockout holds until the requester has been seen low once
         if (r_state == S_GRANT0 && w_state_nxt == S_ABORT)
            r_lock0 <= 1'b1;
         else if (!req0)
            r_lock0 <= 1'b0;

         if (r_state == S_GRANT1 && w_state_nxt == S_ABORT)
            r_lock1 <= 1'b1;
         else if (!req1)
            r_lock1 <= 1'b0;
      end
   end

   assign gnt0        = (r_state == S_GRANT0);
   assign gnt1        = (r_state == S_GRANT1);
   assign timeout_err = r_terr;

   always_comb begin
      drv_ena            = 1'b0;
      drv_rw             = 1'b0;
      drv_start_transfer = 1'b0;
      drv_stop_transfer  = 1'b0;
      drv_r_start        = 1'b0;
      drv_data_wr        = 8'h00;
      data_rd0           = 8'h00;
      busy0              = 1'b1;
      ready0             = 1'b0;
      ack_err0           = 1'b0;
      data_rd1           = 8'h00;
      busy1              = 1'b1;
      ready1             = 1'b0;
      ack_err1           = 1'b0;
      if (r_state == S_GRANT0) begin
         drv_ena            = ena0;
         drv_rw             = rw0;
         drv_start_transfer = start_transfer0;
         drv_stop_transfer  = stop_transfer0;
         drv_r_start        = r_start0;
         drv_data_wr        = data_wr0;
         data_rd0           = drv_data_rd;
         busy0              = drv_busy;
         ready0             = drv_ready;
         ack_err0           = drv_ack_err;
      end else if (r_state == S_GRANT1) begin
         drv_ena            = ena1;
         drv_rw             = rw1;
         drv_start_transfer = start_transfer1;
         drv_stop_transfer  = stop_transfer1;
         drv_r_start        = r_start1;
         drv_data_wr        = data_wr1;
         data_rd1           = drv_data_rd;
         busy1              = drv_busy;
         ready1             = drv_ready;
         ack_err1           = drv_ack_err;
      end
   end

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// Directed-plus-random bench for i2c_bus_arbiter against a transaction-level owner model.
module tb_i2c_bus_arbiter;

   localparam int T = 16;

   logic clk = 1'b0;
   logic rst;
   logic req0, ena0, rw0, start_transfer0, stop_transfer0, r_start0;
   logic req1, ena1, rw1, start_transfer1, stop_transfer1, r_start1;
   logic [7:0] data_wr0, data_wr1, data_rd0, data_rd1;
   logic gnt0, gnt1, busy0, busy1, ready0, ready1, ack_err0, ack_err1;
   logic drv_ena, drv_rw, drv_start_transfer, drv_stop_transfer, drv_r_start;
   logic [7:0] drv_data_wr, drv_data_rd;
   logic drv_busy, drv_ready, drv_ack_err, timeout_err;

   int n_checks = 0;
   int n_fail   = 0;

   // model: who owns the bus (-1 = nobody), plus the gap/abort bookkeeping
   int m_own;
   int m_held;
   int m_last;
   bit m_gap;
   bit m_abort;
   bit m_terr;
   bit m_deny [2];

   always #5 clk = ~clk;

   i2c_bus_arbiter #(.TIMEOUT_CYCLES(T)) dut (
      .clk(clk), .rst(rst),
      .req0(req0), .gnt0(gnt0), .ena0(ena0), .rw0(rw0),
      .start_transfer0(start_transfer0), .stop_transfer0(stop_transfer0),
      .r_start0(r_start0), .data_wr0(data_wr0), .data_rd0(data_rd0),
      .busy0(busy0), .ready0(ready0), .ack_err0(ack_err0),
      .req1(req1), .gnt1(gnt1), .ena1(ena1), .rw1(rw1),
      .start_transfer1(start_transfer1), .stop_transfer1(stop_transfer1),
      .r_start1(r_start1), .data_wr1(data_wr1), .data_rd1(data_rd1),
      .busy1(busy1), .ready1(ready1), .ack_err1(ack_err1),
      .drv_ena(drv_ena), .drv_rw(drv_rw), .drv_start_transfer(drv_start_transfer),
      .drv_stop_transfer(drv_stop_transfer), .drv_r_start(drv_r_start),
      .drv_data_wr(drv_data_wr), .drv_data_rd(drv_data_rd),
      .drv_busy(drv_busy), .drv_ready(drv_ready), .drv_ack_err(drv_ack_err),
      .timeout_err(timeout_err)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_step();
      bit r [2];
      bit ex;
      r[0] = req0;
      r[1] = req1;
      if (rst) begin
         m_own = -1; m_held = 0; m_last = 1; m_gap = 0; m_abort = 0; m_terr = 0;
         m_deny[0] = 0; m_deny[1] = 0;
         return;
      end
      for (int n = 0; n < 2; n++) if (!r[n]) m_deny[n] = 0;
      m_terr = 0;
      if (m_own >= 0) begin
         m_held++;
         ex = !r[m_own] && !drv_busy;
         if (ex) begin
            m_own = -1; m_gap = 1;
         end else if (m_held == T) begin
            m_deny[m_own] = 1; m_own = -1; m_abort = 1; m_terr = 1;
         end
      end else if (m_abort) begin
         if (!drv_busy) begin m_abort = 0; m_gap = 1; end
      end else if (m_gap) begin
         m_gap = 0;
      end else begin
         bit e0, e1;
         e0 = r[0] && !m_deny[0];
         e1 = r[1] && !m_deny[1];
         if (e0 && e1)    m_own = 1 - m_last;
         else if (e0)     m_own = 0;
         else if (e1)     m_own = 1;
         if (m_own >= 0) begin m_last = m_own; m_held = 0; end
      end
   endtask

   task automatic check_all();
      logic [12:0] e_drv;
      logic [10:0] e_rs0, e_rs1;
      e_drv = '0;
      e_rs0 = {1'b1, 1'b0, 1'b0, 8'h00};
      e_rs1 = {1'b1, 1'b0, 1'b0, 8'h00};
      if (m_own == 0) begin
         e_drv = {ena0, rw0, start_transfer0, stop_transfer0, r_start0, data_wr0};
         e_rs0 = {drv_busy, drv_ready, drv_ack_err, drv_data_rd};
      end else if (m_own == 1) begin
         e_drv = {ena1, rw1, start_transfer1, stop_transfer1, r_start1, data_wr1};
         e_rs1 = {drv_busy, drv_ready, drv_ack_err, drv_data_rd};
      end
      chk("gnt0", 32'(gnt0), 32'(m_own == 0));
      chk("gnt1", 32'(gnt1), 32'(m_own == 1));
      chk("timeout_err", 32'(timeout_err), 32'(m_terr));
      chk("drv_bundle", 32'({drv_ena, drv_rw, drv_start_transfer, drv_stop_transfer,
                             drv_r_start, drv_data_wr}), 32'(e_drv));
      chk("req0_status", 32'({busy0, ready0, ack_err0, data_rd0}), 32'(e_rs0));
      chk("req1_status", 32'({busy1, ready1, ack_err1, data_rd1}), 32'(e_rs1));
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      check_all();
   endtask

   task automatic rand_cmd();
      {ena0, rw0, start_transfer0, stop_transfer0, r_start0} = 5'($urandom);
      {ena1, rw1, start_transfer1, stop_transfer1, r_start1} = 5'($urandom);
      data_wr0    = 8'($urandom);
      data_wr1    = 8'($urandom);
      drv_data_rd = 8'($urandom);
      drv_ready   = 1'($urandom);
      drv_ack_err = 1'($urandom);
   endtask

   initial begin
      rst = 1'b1; req0 = 0; req1 = 0; drv_busy = 0;
      rand_cmd();
      #1;
      tick(); tick();
      rst = 1'b0;
      tick();

      // tie after reset goes to 0, then 1 after the release gap
      req0 = 1; req1 = 1; drv_busy = 0;
      rand_cmd(); tick();
      chk("tie_first_gnt0", 32'(gnt0), 32'd1);
      for (int i = 0; i < 3; i++) begin rand_cmd(); tick(); end
      req0 = 0;
      for (int i = 0; i < 4; i++) begin rand_cmd(); tick(); end
      chk("rr_gnt1", 32'(gnt1), 32'd1);

      // grant held across a long busy tail
      drv_busy = 1; req1 = 0;
      for (int i = 0; i < 10; i++) begin rand_cmd(); tick(); end
      chk("hold_while_busy", 32'(gnt1), 32'd1);
      drv_busy = 0;
      for (int i = 0; i < 3; i++) begin rand_cmd(); tick(); end

      // passthrough of a write byte while the other side sees a busy bus
      req0 = 1;
      for (int i = 0; i < 3; i++) begin rand_cmd(); tick(); end
      ena0 = 1; data_wr0 = 8'hA5;
      tick();
      chk("pass_ena", 32'(drv_ena), 32'd1);
      chk("pass_data", 32'(drv_data_wr), 32'hA5);
      chk("other_busy", 32'({busy1, ready1, data_rd1}), 32'h200);

      // watchdog: req0 and busy stuck high
      drv_busy = 1;
      for (int i = 0; i < T + 4; i++) begin rand_cmd(); tick(); end
      chk("aborted", 32'(gnt0), 32'd0);
      drv_busy = 0;
      for (int i = 0; i < 6; i++) begin rand_cmd(); tick(); end
      chk("locked_out", 32'(gnt0), 32'd0);
      req1 = 1;
      for (int i = 0; i < 2; i++) begin rand_cmd(); tick(); end
      chk("other_unaffected", 32'(gnt1), 32'd1);
      req1 = 0;
      for (int i = 0; i < 3; i++) begin rand_cmd(); tick(); end
      req0 = 0; rand_cmd(); tick();
      req0 = 1;
      for (int i = 0; i < 3; i++) begin rand_cmd(); tick(); end
      chk("unlocked_gnt0", 32'(gnt0), 32'd1);
      req0 = 0;
      for (int i = 0; i < 3; i++) begin rand_cmd(); tick(); end

      // reset pulse in the middle of a grant to 1
      req1 = 1; drv_busy = 1;
      for (int i = 0; i < 3; i++) begin rand_cmd(); tick(); end
      ena1 = 1;
      rst = 1; tick();
      chk("rst_gnt1", 32'(gnt1), 32'd0);
      chk("rst_drv_ena", 32'(drv_ena), 32'd0);
      rst = 0; req0 = 1; drv_busy = 0;
      rand_cmd(); tick();
      chk("post_rst_tie", 32'(gnt0), 32'd1);
      req0 = 0; req1 = 0;
      for (int i = 0; i < 3; i++) begin rand_cmd(); tick(); end

      // random phases with varying busy pressure
      for (int b = 0; b < 40; b++) begin
         int busy_pct = $urandom_range(0, 100);
         int req_pct  = $urandom_range(20, 100);
         for (int i = 0; i < 12; i++) begin
            req0     = ($urandom_range(0, 99) < req_pct);
            req1     = ($urandom_range(0, 99) < req_pct);
            drv_busy = ($urandom_range(0, 99) < busy_pct);
            rst      = ($urandom_range(0, 199) == 0);
            rand_cmd();
            tick();
         end
      end
      rst = 0;

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/i2c_bus_arbiter.md
I2C_BUS_ARBITER -- requirements
Module: i2c_bus_arbiter

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 1000000, max cycles one grant may be held (20 ms at 50 MHz).
REQ-002 One clock; reset is synchronous and active-high.
REQ-003 clk  in  1  system clock; all state changes on its rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 reqN  in  1  (N = 0, 1) requester N wants the bus; level, held for the whole transaction.
REQ-006 gntN  out  1  requester N owns the bus.
REQ-007 enaN, rwN, start_transferN, stop_transferN, r_startN  in  1 each  requester N command strobes, I2C_Driver semantics.
REQ-008 data_wrN  in  8  requester N write byte.
REQ-009 data_rdN  out  8  read byte returned to requester N.
REQ-010 busyN, readyN, ack_errN  out  1 each  driver status as seen by requester N.
REQ-011 drv_ena, drv_rw, drv_start_transfer, drv_stop_transfer, drv_r_start  out  1 each  to the shared I2C_Driver.
REQ-012 drv_data_wr  out  8  to driver.
REQ-013 drv_data_rd  in  8  from driver.
REQ-014 drv_busy, drv_ready, drv_ack_err  in  1 each  from driver.
REQ-015 timeout_err  out  1  one-cycle pulse when a grant is revoked by the watchdog.

Function
REQ-016 The FSM SHALL have states IDLE, GRANT0, GRANT1, RELEASE, ABORT; gnt0 = (state==GRANT0), gnt1 = (state==GRANT1), both registered.
REQ-017 IDLE: only req0 -> GRANT0; only req1 -> GRANT1; both -> the requester not equal to last_grant; none -> stay.
REQ-018 Grant latency SHALL be exactly one cycle: req sampled high in IDLE at edge k, gnt high after edge k.
REQ-019 On entering GRANTx, last_grant SHALL be set to x (round-robin pointer).
REQ-020 GRANTx: the driver outputs SHALL equal requester x's inputs combinationally; requester x SHALL see drv_data_rd, drv_busy, drv_ready, drv_ack_err unmodified.
REQ-021 Non-granted requester SHALL see busyN=1, readyN=0, ack_errN=0, data_rdN=0; its strobes are ignored.
REQ-022 In every state other than GRANTx, all drv_* outputs SHALL be 0.
REQ-023 GRANTx -> RELEASE when reqx=0 and drv_busy=0 in the same cycle; reqx=0 while drv_busy=1 SHALL keep the grant until drv_busy falls.
REQ-024 RELEASE SHALL last exactly one cycle then go to IDLE (two-cycle minimum gap between grants).
REQ-025 A 20-bit watchdog SHALL clear on entry to GRANTx and increment each GRANTx cycle; when it reaches TIMEOUT_CYCLES-1 with the exit condition false, go to ABORT.
REQ-026 ABORT: gnt0=gnt1=0, drv_* = 0; timeout_err=1 in the first ABORT cycle only; exit to RELEASE when drv_busy=0.
REQ-027 The timed-out requester SHALL be denied while its req stays high continuously: IDLE SHALL not grant it until it has been sampled low at least once; the other requester is unaffected.
REQ-028 A request arriving during RELEASE or ABORT SHALL be held off, not lost, and evaluated in IDLE.
REQ-029 ack_err from the driver SHALL NOT end a grant; only reqx release or timeout does.

Reset
REQ-030 rst=1 SHALL force state IDLE, last_grant=1 (requester 0 wins first tie), watchdog=0, lockout flags cleared, gntN=0, timeout_err=0, all drv_* outputs 0, from the next edge.
REQ-031 rst asserted mid-transaction SHALL drop the grant immediately; the driver is not waited for.

Verification
REQ-032 After reset, req0=req1=1 on the same edge -> gnt0=1 one cycle later; req0 drops with drv_busy=0 -> RELEASE, IDLE, then gnt1=1 (4 cycles after the req0 drop).
REQ-033 GRANT1, req1 drops while drv_busy=1 for 10 cycles -> gnt1 stays 1 until drv_busy falls, then RELEASE; no drv_* activity in the gap.
REQ-034 GRANT0 with ena0=1, data_wr0=0xA5 -> drv_ena=1, drv_data_wr=0xA5 same cycle; requester 1 sees busy1=1, ready1=0, data_rd1=0x00.
REQ-035 TIMEOUT_CYCLES=16, req0 held high, drv_busy=1 -> ABORT after 16 GRANT0 cycles, one-cycle timeout_err; after drv_busy=0, RELEASE, IDLE; req0 still high gets no grant until it toggles low.
REQ-036 rst pulsed during GRANT1 -> gnt1=0 and drv_ena=0 after the edge; the next tie grants requester 0.
